regbank_write_issuer: RTL
=========================

Name: regbank_write_issuer

Overview:
- Initiator side of the multi-track register bank write port.
- Collects writeback requests from the datapath through a valid/ready handshake and buffers them in a small FIFO.
- Drives the bank's registered write interface (RegWrite, WriteRegister, WriteData, writepId, Jal, rwc, PC) at one write per cycle.
- Also runs a track-clear sequence that zeroes registers 1..31 of one process track, used on process creation or teardown.

Parameters:
- DATA_WIDTH, 32, width of data, PC and process-id fields
- TRACKS, 2, number of process register tracks in the bank
- FIFO_DEPTH, 4, request buffer entries (power of two, at least 2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  write request present
- req_ready  out  1  issuer can accept a request this cycle
- req_reg  in  5  destination register index
- req_data  in  DATA_WIDTH  write data
- req_pid  in  DATA_WIDTH  destination process track
- req_jal  in  1  jal link write (bank writes PC+1 to reg 31)
- req_rwc  in  1  cross-track write to track 1
- req_pc  in  DATA_WIDTH  PC for jal link
- clr_start  in  1  request clear of track clr_pid
- clr_pid  in  DATA_WIDTH  track to clear
- clr_ready  out  1  clear request can be accepted
- clr_done  out  1  one-cycle pulse when the clear completes
- err_pid  out  1  one-cycle pulse: request or clear dropped because pid >= TRACKS
- RegWrite  out  1  bank write enable
- WriteRegister  out  5  bank write index
- WriteData  out  DATA_WIDTH  bank write data
- writepId  out  DATA_WIDTH  bank write track
- Jal  out  1  bank jal select
- rwc  out  1  bank cross-track select
- PC  out  DATA_WIDTH  bank PC

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - All outputs are 0, except clr_ready=1 and req_ready=1.
  - FIFO is empty and the state machine is IDLE.
- Request handshake:
  - A transfer occurs at a rising edge when req_valid and req_ready are both 1.
  - req_ready = (count < FIFO_DEPTH) and state==IDLE.
  - If req_pid >= TRACKS, the request is consumed but not enqueued, and err_pid pulses on the next cycle.
  - A request with req_rwc=1 ignores req_pid for range checking.
- Issue:
  - At each edge in IDLE with the FIFO non-empty, the head is popped into the registered bank outputs and RegWrite<=1.
  - Otherwise RegWrite<=0. The other outputs hold their last value while RegWrite=0.
  - Latency: a request accepted at edge k drives RegWrite=1 after edge k+1, and the bank commits it at edge k+2.
  - Throughput is one write per cycle. Entries issue in strict FIFO order.
  - Simultaneous push and pop when count==FIFO_DEPTH is not possible because req_ready=0. When 0<count<FIFO_DEPTH, push and pop in the same edge leave count unchanged.
- Clear state machine (IDLE, DRAIN, CLEAR, DONE):
  - IDLE: clr_ready=1. On clr_start, latch clr_pid and go to DRAIN.
    - If clr_pid >= TRACKS, pulse err_pid and stay in IDLE.
    - If clr_start and a valid request arrive on the same edge, the request is accepted first (req_ready is evaluated in IDLE). The clear follows after the drain.
  - DRAIN: clr_ready=0, req_ready=0. Pops continue until the FIFO is empty, then go to CLEAR with an index counter of 1.
  - CLEAR: each cycle drive RegWrite=1, WriteRegister=counter, WriteData=0, writepId=latched pid, Jal=0, rwc=0, then increment. After index 31 is issued (31 writes, register 0 never written), go to DONE.
  - DONE: RegWrite<=0, clr_done pulses for one cycle, return to IDLE.
  - Total clear latency with an empty FIFO is 33 edges from the clr_start edge to clr_done high.
- Reset mid-operation: the FIFO is flushed, any in-flight clear is aborted without clr_done, and RegWrite drops immediately (asynchronous).
- Width rules: the pid comparison is unsigned and full DATA_WIDTH. The counter is 5 bits with no wrap past 31.

Test Plan:
- Single request reg=5, data=0xDEADBEEF, pid=1, accepted at edge 0 -> RegWrite=1 after edge 1 with WriteRegister=5, WriteData=0xDEADBEEF, writepId=1; RegWrite=0 after edge 2.
- Back-to-back burst of 6 requests, reg=1..6 -> req_ready deasserts only when 4 entries are pending; outputs show regs 1..6 in order on 6 consecutive RegWrite cycles.
- Request with pid=2 (TRACKS=2) -> no RegWrite; err_pid pulses once. Same request with rwc=1 -> issued with rwc=1.
- jal request with pc=0x40 -> Jal=1, PC=0x40 on the issue cycle.
- clr_start with pid=1 while 3 entries are queued -> the 3 writes issue first, then 31 writes reg=1..31 with data=0 and writepId=1, then a single clr_done pulse; req_ready=0 throughout.
- Assert reset during CLEAR at index 10 -> RegWrite=0 immediately, no clr_done; after release clr_ready=1 and the FIFO is empty.

Source files
------------

// File: rtl/regbank_write_issuer_if.sv
// regbank_write_issuer_if: request, clear and bank-write signals shared by the datapath,
// the write issuer and the register bank.
interface regbank_write_issuer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [4:0]            req_reg;
    logic [DATA_WIDTH-1:0] req_data;
    logic [DATA_WIDTH-1:0] req_pid;
    logic                  req_jal;
    logic                  req_rwc;
    logic [DATA_WIDTH-1:0] req_pc;
    logic                  clr_start;
    logic [DATA_WIDTH-1:0] clr_pid;
    logic                  clr_ready;
    logic                  clr_done;
    logic                  err_pid;
    logic                  RegWrite;
    logic [4:0]            WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [DATA_WIDTH-1:0] writepId;
    logic                  Jal;
    logic                  rwc;
    logic [DATA_WIDTH-1:0] PC;

    modport master (
        output req_valid, req_reg, req_data, req_pid, req_jal, req_rwc, req_pc, clr_start, clr_pid,
        input  req_ready, clr_ready, clr_done, err_pid,
        input  RegWrite, WriteRegister, WriteData, writepId, Jal, rwc, PC
    );

    modport slave (
        input  req_valid, req_reg, req_data, req_pid, req_jal, req_rwc, req_pc, clr_start, clr_pid,
        output req_ready, clr_ready, clr_done, err_pid,
        output RegWrite, WriteRegister, WriteData, writepId, Jal, rwc, PC
    );
endinterface

// File: rtl/regbank_write_issuer.sv
// regbank_write_issuer: buffers datapath writebacks in a small FIFO and issues them to the
// register bank one per cycle; also sequences a zeroing sweep of registers 1..31 of one track.
module regbank_write_issuer #(
    parameter int DATA_WIDTH = 32,
    parameter int TRACKS     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic                   clock,
    input logic                   reset,
    regbank_write_issuer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] TRACK_LIMIT = DATA_WIDTH'(TRACKS);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [CW-1:0]         count;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [4:0]            idx;
    logic [DATA_WIDTH-1:0] clr_track;
    logic [4:0]            f_reg  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] f_data [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] f_pid  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] f_pc   [FIFO_DEPTH];
    logic                  f_jal  [FIFO_DEPTH];
    logic                  f_rwc  [FIFO_DEPTH];
    logic                  accept;
    logic                  pid_ok;
    logic                  push;
    logic                  pop;
    logic                  clr_bad;
    logic                  clr_go;

    assign bus.req_ready = count < FULL && state == IDLE;
    assign bus.clr_ready = state == IDLE;
    assign accept  = bus.req_valid && bus.req_ready;
    // Cross-track writes always target track 1, so their pid field is not range checked.
    assign pid_ok  = bus.req_rwc || bus.req_pid < TRACK_LIMIT;
    assign push    = accept && pid_ok;
    assign pop     = (state == IDLE || state == DRAIN) && count != '0;
    assign clr_bad = state == IDLE && bus.clr_start && bus.clr_pid >= TRACK_LIMIT;
    assign clr_go  = state == IDLE && bus.clr_start && bus.clr_pid < TRACK_LIMIT;

    always_comb begin
        state_next = state == IDLE  ? (clr_go ? DRAIN : IDLE) :
                     state == DRAIN ? (count == '0 ? CLEAR : DRAIN) :
                     state == CLEAR ? (idx == 5'd31 ? DONE : CLEAR) : IDLE;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            f_reg[wr_ptr]  <= bus.req_reg;
            f_data[wr_ptr] <= bus.req_data;
            f_pid[wr_ptr]  <= bus.req_pid;
            f_pc[wr_ptr]   <= bus.req_pc;
            f_jal[wr_ptr]  <= bus.req_jal;
            f_rwc[wr_ptr]  <= bus.req_rwc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            count             <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            idx               <= '0;
            clr_track         <= '0;
            bus.err_pid       <= 1'b0;
            bus.clr_done      <= 1'b0;
            bus.RegWrite      <= 1'b0;
            bus.WriteRegister <= '0;
            bus.WriteData     <= '0;
            bus.writepId      <= '0;
            bus.Jal           <= 1'b0;
            bus.rwc           <= 1'b0;
            bus.PC            <= '0;
        end else begin
            state        <= state_next;
            count        <= count + CW'(push) - CW'(pop);
            wr_ptr       <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr       <= pop ? rd_ptr + 1'b1 : rd_ptr;
            clr_track    <= clr_go ? bus.clr_pid : clr_track;
            idx          <= state == DRAIN ? 5'd1 : (state == CLEAR && idx != 5'd31) ? idx + 5'd1 : idx;
            bus.err_pid  <= (accept && !pid_ok) || clr_bad;
            bus.clr_done <= state == DONE;
            bus.RegWrite <= pop || state == CLEAR;
            if (pop) begin
                bus.WriteRegister <= f_reg[rd_ptr];
                bus.WriteData     <= f_data[rd_ptr];
                bus.writepId      <= f_pid[rd_ptr];
                bus.Jal           <= f_jal[rd_ptr];
                bus.rwc           <= f_rwc[rd_ptr];
                bus.PC            <= f_pc[rd_ptr];
            end else if (state == CLEAR) begin
                bus.WriteRegister <= idx;
                bus.WriteData     <= '0;
                bus.writepId      <= clr_track;
                bus.Jal           <= 1'b0;
                bus.rwc           <= 1'b0;
            end
        end
    end
endmodule
